// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity helper and the start-bit half-period macro.
// The TX block imports the same package.
`define UART_HALF(os) (((os) - 1) / 2)

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  // Parity bit that makes the total count of ones even (odd=0) or odd (odd=1).
  function automatic logic parity_calc(input logic [15:0] vec, input logic odd);
    return (^vec) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an idle-high asynchronous line; both stages reset to 1.
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable width, oversampling, optional parity, 1 or 2 stop bits.
// Emits registered 1-cycle strobes for good data, framing and parity errors.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serialInput,
  output logic [DATA_BITS-1:0] data,
  output logic                 dataValid,
  output logic                 frameError,
  output logic                 parityError,
  output logic                 busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(`UART_HALF(OVERSAMPLE));
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  logic rxs;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (serialInput),
    .q   (rxs)
  );

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 par_err_q, par_err_d;
  logic                 stop_err_q, stop_err_d;
  logic                 mid_bit;
  logic                 stop_bad;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    data_d     = data_q;
    par_err_d  = par_err_q;
    stop_err_d = stop_err_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    perr_d     = 1'b0;
    stop_bad   = 1'b0;
    mid_bit    = (cnt_q == CNT_LAST);

    case (state_q)
      IDLE: begin
        par_err_d  = 1'b0;
        stop_err_d = 1'b0;
        if (!rxs) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) state_d = rxs ? IDLE : DATA;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      DATA: begin
        if (mid_bit) begin
          shreg_d[bit_idx_q] = rxs;
          if (bit_idx_q == DATA_LAST) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            cnt_d     = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY: begin
        if (mid_bit) begin
          par_err_d = parity_calc(16'(shreg_q), PARITY_ODD != 0) ^ rxs;
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (mid_bit) begin
          stop_bad = stop_err_q | ~rxs;
          if (bit_idx_q == STOP_LAST) begin
            perr_d = par_err_q;
            if (stop_bad) begin
              ferr_d  = 1'b1;
              state_d = BREAK;
            end else begin
              data_d  = shreg_q;
              valid_d = ~par_err_q;
              state_d = IDLE;
            end
          end else begin
            stop_err_d = stop_bad;
            bit_idx_d  = bit_idx_q + 1'b1;
            cnt_d      = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // Held-low line or break: only a released line may re-arm start detection.
      BREAK: begin
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d     = '0;
      bit_idx_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
      par_err_q  <= par_err_d;
      stop_err_q <= stop_err_d;
    end
  end

  assign data        = data_q;
  assign dataValid   = valid_q;
  assign frameError  = ferr_q;
  assign parityError = perr_q;
  assign busy        = (state_q != IDLE);

endmodule
